// File: rtl/fg_rate_burst_gen_pkg.sv
// fg_pkg: shared definitions for the rate/burst flow generator.
//   MODE_FINITE / MODE_CONT : flow mode encodings
//   fg_acc_width()          : width of the per-slot credit accumulator
//   fg_slot_flags_t         : width-independent part of a flow slot record;
//                             the parameter-sized fields (dest, rate, length,
//                             burst length, credit) live in per-slot arrays in
//                             the top so they can follow its parameters.
package fg_pkg;

    localparam logic MODE_FINITE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    // Credit holds up to 2*cost, where cost = burst_len << rate_scale; two
    // spare bits keep the saturating add clear of overflow.
    function automatic int fg_acc_width(input int len_width, input int rate_scale);
        return len_width + rate_scale + 2;
    endfunction

    typedef struct packed {
        logic active;
        logic mode;
    } fg_slot_flags_t;

endpackage

// File: rtl/fg_free_slot_enc.sv
// fg_free_slot_enc: lowest-index free-slot finder for the flow table.
//   active_i : per-slot active bits (a slot is free when its bit is 0)
//   any_o    : at least one slot is free
//   index_o  : lowest-index free slot (0 when none is free)
module fg_free_slot_enc #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [(1<<ADDR_WIDTH)-1:0] active_i,
    output logic                       any_o,
    output logic [ADDR_WIDTH-1:0]      index_o
);

    localparam int SLOTS = 1 << ADDR_WIDTH;

    // Walk from the top down so the last hit, the lowest index, wins.
    always_comb begin
        any_o   = 1'b0;
        index_o = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active_i[i]) begin
                any_o   = 1'b1;
                index_o = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/fg_rate_burst_gen.sv
// fg_rate_burst_gen: multi-flow, credit-paced burst descriptor generator.
//   clk, rst                    : clock, synchronous active-low reset
//   input_fd_*                  : flow descriptor in (ready/valid); input_fd_flow
//                                 reports the slot the next descriptor takes
//   cancel_valid / cancel_flow  : one-cycle strobe freeing an active slot
//   output_bd_*                 : burst descriptor out (ready/valid)
//   done_valid / done_flow      : one-cycle pulse when a finite flow completes
//   busy, active_flows          : activity status
// A scan pointer visits one slot per unstalled cycle. A visited slot emits a
// burst when its credit covers one burst (cost = burst_len << RATE_SCALE);
// every emitting or waiting visit accrues rate << FLOW_ADDR_WIDTH credit,
// because a slot is only seen once per FLOWS cycles, so the long-run byte
// rate matches the programmed rate.
module fg_rate_burst_gen
    import fg_pkg::*;
#(
    parameter int FLOW_ADDR_WIDTH = 5,
    parameter int DEST_WIDTH      = 8,
    parameter int RATE_WIDTH      = 16,
    parameter int LEN_WIDTH       = 32,
    parameter int RATE_SCALE      = 8
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         input_fd_valid,
    output logic                         input_fd_ready,
    input  logic [DEST_WIDTH-1:0]        input_fd_dest,
    input  logic [RATE_WIDTH-1:0]        input_fd_rate,
    input  logic [LEN_WIDTH-1:0]         input_fd_len,
    input  logic [LEN_WIDTH-1:0]         input_fd_burst_len,
    input  logic                         input_fd_mode,
    output logic [FLOW_ADDR_WIDTH-1:0]   input_fd_flow,

    input  logic                         cancel_valid,
    input  logic [FLOW_ADDR_WIDTH-1:0]   cancel_flow,

    output logic                         output_bd_valid,
    input  logic                         output_bd_ready,
    output logic [DEST_WIDTH-1:0]        output_bd_dest,
    output logic [FLOW_ADDR_WIDTH-1:0]   output_bd_flow,
    output logic [LEN_WIDTH-1:0]         output_bd_burst_len,

    output logic                         done_valid,
    output logic [FLOW_ADDR_WIDTH-1:0]   done_flow,

    output logic                         busy,
    output logic [FLOW_ADDR_WIDTH:0]     active_flows
);

    localparam int FLOWS     = 1 << FLOW_ADDR_WIDTH;
    localparam int CNT_WIDTH = FLOW_ADDR_WIDTH + 1;
    localparam int ACC_WIDTH = fg_acc_width(LEN_WIDTH, RATE_SCALE);
    localparam int INC_WIDTH = RATE_WIDTH + FLOW_ADDR_WIDTH;
    localparam int SUM_WIDTH = ((ACC_WIDTH > INC_WIDTH) ? ACC_WIDTH : INC_WIDTH) + 1;

    // Flow table
    fg_slot_flags_t [FLOWS-1:0]                  flags_q, flags_d;
    logic           [FLOWS-1:0][DEST_WIDTH-1:0]  dest_q,  dest_d;
    logic           [FLOWS-1:0][RATE_WIDTH-1:0]  rate_q,  rate_d;
    logic           [FLOWS-1:0][LEN_WIDTH-1:0]   rem_q,   rem_d;
    logic           [FLOWS-1:0][LEN_WIDTH-1:0]   blen_q,  blen_d;
    logic           [FLOWS-1:0][ACC_WIDTH-1:0]   cred_q,  cred_d;

    // Scan pointer and registered outputs
    logic [FLOW_ADDR_WIDTH-1:0] p_q, p_d;
    logic                       bd_valid_q, bd_valid_d;
    logic [DEST_WIDTH-1:0]      bd_dest_q, bd_dest_d;
    logic [FLOW_ADDR_WIDTH-1:0] bd_flow_q, bd_flow_d;
    logic [LEN_WIDTH-1:0]       bd_len_q, bd_len_d;
    logic                       done_valid_q, done_valid_d;
    logic [FLOW_ADDR_WIDTH-1:0] done_flow_q, done_flow_d;
    logic                       busy_q, busy_d;
    logic [CNT_WIDTH-1:0]       active_cnt_q, active_cnt_d;

    // Free-slot search over the registered table
    logic [FLOWS-1:0]           active_vec;
    logic                       free_any;
    logic [FLOW_ADDR_WIDTH-1:0] free_idx;

    always_comb begin
        active_vec = '0;
        for (int i = 0; i < FLOWS; i++) active_vec[i] = flags_q[i].active;
    end

    fg_free_slot_enc #(
        .ADDR_WIDTH (FLOW_ADDR_WIDTH)
    ) u_free_enc (
        .active_i (active_vec),
        .any_o    (free_any),
        .index_o  (free_idx)
    );

    assign input_fd_ready = rst & free_any;
    assign input_fd_flow  = free_idx;

    // Visit arithmetic for the slot under the scan pointer
    logic                 stall, cancel_hit, accept;
    logic                 v_active, v_finite, v_drop, v_emit;
    logic [LEN_WIDTH-1:0] v_blen, v_rem, v_len;
    logic [ACC_WIDTH-1:0] v_cred, v_cost, v_cap, v_new_cred;
    logic [SUM_WIDTH-1:0] v_base, v_sum;

    assign stall      = bd_valid_q & ~output_bd_ready;
    assign cancel_hit = cancel_valid & flags_q[cancel_flow].active;
    assign accept     = input_fd_valid & input_fd_ready;

    always_comb begin
        // A cancel landing on the visited slot takes precedence over the visit.
        v_active = flags_q[p_q].active & ~(cancel_hit & (cancel_flow == p_q));
        v_finite = (flags_q[p_q].mode == MODE_FINITE);
        v_blen   = blen_q[p_q];
        v_rem    = rem_q[p_q];
        v_cred   = cred_q[p_q];
        v_cost   = ACC_WIDTH'(v_blen) << RATE_SCALE;
        v_cap    = v_cost << 1;
        v_drop   = (v_blen == '0) | (v_finite & (v_rem == '0));
        v_emit   = ~v_drop & (v_cred >= v_cost);
        v_len    = (v_finite && (v_rem < v_blen)) ? v_rem : v_blen;
        v_base   = v_emit ? SUM_WIDTH'(v_cred - v_cost) : SUM_WIDTH'(v_cred);
        v_sum    = v_base + (SUM_WIDTH'(rate_q[p_q]) << FLOW_ADDR_WIDTH);
        v_new_cred = (v_sum > SUM_WIDTH'(v_cap)) ? v_cap : v_sum[ACC_WIDTH-1:0];
    end

    // Next state: visit, then cancel, then accept. The accepted slot is free in
    // the registered table, so neither the visit nor the cancel can touch it.
    always_comb begin
        flags_d      = flags_q;
        dest_d       = dest_q;
        rate_d       = rate_q;
        rem_d        = rem_q;
        blen_d       = blen_q;
        cred_d       = cred_q;
        p_d          = p_q;
        bd_valid_d   = bd_valid_q;
        bd_dest_d    = bd_dest_q;
        bd_flow_d    = bd_flow_q;
        bd_len_d     = bd_len_q;
        done_valid_d = 1'b0;
        done_flow_d  = done_flow_q;

        // Backpressure freezes the pointer and every credit.
        if (!stall) begin
            p_d = p_q + FLOW_ADDR_WIDTH'(1);
            if (output_bd_ready) bd_valid_d = 1'b0;
            if (v_active) begin
                if (v_drop) begin
                    flags_d[p_q].active = 1'b0;
                    if (v_finite) begin
                        done_valid_d = 1'b1;
                        done_flow_d  = p_q;
                    end
                end else begin
                    cred_d[p_q] = v_new_cred;
                    if (v_emit) begin
                        bd_valid_d = 1'b1;
                        bd_dest_d  = dest_q[p_q];
                        bd_flow_d  = p_q;
                        bd_len_d   = v_len;
                        if (v_finite) begin
                            rem_d[p_q] = v_rem - v_len;
                            if (v_rem == v_len) begin
                                flags_d[p_q].active = 1'b0;
                                done_valid_d        = 1'b1;
                                done_flow_d         = p_q;
                            end
                        end
                    end
                end
            end
        end

        if (cancel_hit) flags_d[cancel_flow].active = 1'b0;

        // Preloaded credit makes the first burst go out on the first visit.
        if (accept) begin
            flags_d[free_idx].active = 1'b1;
            flags_d[free_idx].mode   = input_fd_mode;
            dest_d[free_idx]         = input_fd_dest;
            rate_d[free_idx]         = input_fd_rate;
            rem_d[free_idx]          = input_fd_len;
            blen_d[free_idx]         = input_fd_burst_len;
            cred_d[free_idx]         = ACC_WIDTH'(input_fd_burst_len) << RATE_SCALE;
        end
    end

    // Status follows the next table state so it lines up with the edge that
    // changes the table.
    always_comb begin
        active_cnt_d = '0;
        busy_d       = bd_valid_d;
        for (int i = 0; i < FLOWS; i++) begin
            active_cnt_d = active_cnt_d + CNT_WIDTH'(flags_d[i].active);
            busy_d       = busy_d | flags_d[i].active;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q      <= '0;
            dest_q       <= '0;
            rate_q       <= '0;
            rem_q        <= '0;
            blen_q       <= '0;
            cred_q       <= '0;
            p_q          <= '0;
            bd_valid_q   <= 1'b0;
            bd_dest_q    <= '0;
            bd_flow_q    <= '0;
            bd_len_q     <= '0;
            done_valid_q <= 1'b0;
            done_flow_q  <= '0;
            busy_q       <= 1'b0;
            active_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            dest_q       <= dest_d;
            rate_q       <= rate_d;
            rem_q        <= rem_d;
            blen_q       <= blen_d;
            cred_q       <= cred_d;
            p_q          <= p_d;
            bd_valid_q   <= bd_valid_d;
            bd_dest_q    <= bd_dest_d;
            bd_flow_q    <= bd_flow_d;
            bd_len_q     <= bd_len_d;
            done_valid_q <= done_valid_d;
            done_flow_q  <= done_flow_d;
            busy_q       <= busy_d;
            active_cnt_q <= active_cnt_d;
        end
    end

    assign output_bd_valid     = bd_valid_q;
    assign output_bd_dest      = bd_dest_q;
    assign output_bd_flow      = bd_flow_q;
    assign output_bd_burst_len = bd_len_q;
    assign done_valid          = done_valid_q;
    assign done_flow           = done_flow_q;
    assign busy                = busy_q;
    assign active_flows        = active_cnt_q;

endmodule
